// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI transaction sequencer between spislave and a register file.
// Optional feature macro: SPI_REG_CTRL_AUTOINC_EN. When it is defined, reg_addr steps
// by one after each data byte. When it is undefined, reg_addr holds the command address.
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   ss                    SPI slave select (active-low, asynchronous to clk)
//   sr_rdy, sr_data_o     spislave byte-complete level and received byte
//   sr_ld, sr_data_i      one-clk load strobe and byte to preload into spislave
//   status_i              status byte returned while the command byte shifts
//   reg_addr, reg_wr,     register file address, write strobe and write data
//   reg_wdata
//   reg_rd, reg_rdata     read strobe; read data is valid the clk after reg_rd
//   busy                  high while a frame is active
//   ovr, ovr_clr          sticky overrun flag and its synchronous clear
module spi_reg_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic                  sr_rdy,
    input  logic [DATA_WIDTH-1:0] sr_data_o,
    output logic                  sr_ld,
    output logic [DATA_WIDTH-1:0] sr_data_i,
    input  logic [DATA_WIDTH-1:0] status_i,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic                  reg_wr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_rd,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  busy,
    output logic                  ovr,
    input  logic                  ovr_clr
);
    typedef enum logic [2:0] {IDLE, CMD, WR, RD_REQ, RD_LD, RD} state_t;
    state_t state_q, state_d;
    // [0] and [1] are the synchronizer; [2] holds the previous synced value for edge detection
    logic [2:0] ss_sync_q;
    logic rdy_q;
    logic sr_ld_q, sr_ld_d, reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d;
    logic busy_q, busy_d, ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0] sr_data_i_q, sr_data_i_d, reg_wdata_q, reg_wdata_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d, addr_step;
    logic frame_start, frame_end, byte_ev;
    assign frame_start = ss_sync_q[2] & ~ss_sync_q[1];
    assign frame_end   = ~ss_sync_q[2] & ss_sync_q[1];
    assign byte_ev     = sr_rdy & ~rdy_q;
`ifdef SPI_REG_CTRL_AUTOINC_EN
    assign addr_step = reg_addr_q + ADDR_WIDTH'(1);
`else
    assign addr_step = reg_addr_q;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ss_sync_q   <= 3'b111;
            rdy_q       <= 1'b0;
            sr_ld_q     <= 1'b0;
            sr_data_i_q <= '0;
            reg_addr_q  <= '0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= '0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_sync_q   <= {ss_sync_q[1:0], ss};
            rdy_q       <= sr_rdy;
            sr_ld_q     <= sr_ld_d;
            sr_data_i_q <= sr_data_i_d;
            reg_addr_q  <= reg_addr_d;
            reg_wr_q    <= reg_wr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_rd_q    <= reg_rd_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (frame_end) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = frame_start ? CMD : IDLE;
                CMD:     state_d = byte_ev ? (sr_data_o[7] ? WR : RD_REQ) : CMD;
                WR:      state_d = WR;
                RD_REQ:  state_d = RD_LD;
                RD_LD:   state_d = RD;
                RD:      state_d = byte_ev ? RD_REQ : RD;
                default: state_d = IDLE;
            endcase
        end
    end
    // Frame end takes priority over everything: it drops any strobe that would
    // otherwise fire this clk and also suppresses overrun detection.
    always_comb begin
        sr_ld_d     = 1'b0;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        sr_data_i_d = sr_data_i_q;
        reg_wdata_d = reg_wdata_q;
        busy_d      = busy_q;
        ovr_d       = ovr_q & ~ovr_clr;
        // the write address advances the clk after its strobe, so the strobe sees the old address
        reg_addr_d  = reg_wr_q ? addr_step : reg_addr_q;
        if (frame_end) begin
            busy_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sr_ld_d     = frame_start;
                    sr_data_i_d = frame_start ? status_i : sr_data_i_q;
                    busy_d      = frame_start | busy_q;
                end
                CMD: begin
                    reg_addr_d = byte_ev ? sr_data_o[ADDR_WIDTH-1:0] : reg_addr_q;
                    reg_rd_d   = byte_ev & ~sr_data_o[7];
                end
                WR: begin
                    reg_wr_d    = byte_ev;
                    reg_wdata_d = byte_ev ? sr_data_o : reg_wdata_q;
                end
                RD_REQ: ovr_d = ovr_d | byte_ev;
                RD_LD: begin
                    ovr_d       = ovr_d | byte_ev;
                    sr_ld_d     = 1'b1;
                    sr_data_i_d = reg_rdata;
                end
                RD: begin
                    reg_addr_d = byte_ev ? addr_step : reg_addr_q;
                    reg_rd_d   = byte_ev;
                end
                default: ;
            endcase
        end
    end
    assign sr_ld     = sr_ld_q;
    assign sr_data_i = sr_data_i_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;
    assign ovr       = ovr_q;
endmodule
